// File: rtl/rx_ltssm.sv
// ---------------------------------------------------------------------------
// rx_ltssm -- receive-side companion of the TX LTSSM.
//
// Watches the decoded, lane-aligned ordered sets (OS) and counts consecutive
// qualifying TS1/TS2/IDLE sets for the state commanded by the main LTSSM. It
// raises a one-cycle RXFinishFlag, with the requested next state on RXExitTo,
// once per state visit when the receive exit condition is met. An upstream
// port also captures the link number proposed by the downstream port. Both
// port types latch the negotiated rate.
//
// Ports:
//   Pclk, Reset        clock, synchronous active-low reset
//   SetRXState   [3:0] state commanded by the main LTSSM (TX LTSSM encoding)
//   RXFinishFlag       1-cycle pulse: exit condition met
//   RXExitTo     [3:0] requested next state, valid while RXFinishFlag=1
//   OSValid            1-cycle strobe: one complete OS on the Rx* inputs
//   OSType       [2:0] 0 TS1, 1 TS2, 4 IDLE, anything else ignored
//   RxLinkNum/RxLinkPad, RxLaneNum/RxLanePad, RxRate: decoded TS fields
//   ReadLinkNum  [7:0] link number held by the TX side (downstream reference)
//   WriteLinkNum [7:0] captured link number (upstream), WriteLinkNumFlag strobe
//   LinkRate     [2:0] negotiated rate = min(RxRate, MAX_GEN)
// ---------------------------------------------------------------------------
module rx_ltssm #(
    parameter int DEVICETYPE = 0,   // 0 = downstream, 1 = upstream
    parameter int MAX_GEN    = 1,
    parameter int POLL_CNT   = 8,
    parameter int CFG_CNT    = 2,
    parameter int IDLE_CNT   = 8
) (
    input  logic       Pclk,
    input  logic       Reset,
    input  logic [3:0] SetRXState,
    output logic       RXFinishFlag,
    output logic [3:0] RXExitTo,
    input  logic       OSValid,
    input  logic [2:0] OSType,
    input  logic [7:0] RxLinkNum,
    input  logic       RxLinkPad,
    input  logic [7:0] RxLaneNum,
    input  logic       RxLanePad,
    input  logic [2:0] RxRate,
    input  logic [7:0] ReadLinkNum,
    output logic [7:0] WriteLinkNum,
    output logic       WriteLinkNumFlag,
    output logic [2:0] LinkRate
);

    typedef enum logic [3:0] {
        DetectQuiet                 = 4'd0,
        DetectActive                = 4'd1,
        PollingActive               = 4'd2,
        PollingConfigration         = 4'd3,
        ConfigrationLinkWidthStart  = 4'd4,
        ConfigrationLinkWidthAccept = 4'd5,
        ConfigrationLaneNumWait     = 4'd6,
        ConfigrationLaneNumActive   = 4'd7,
        ConfigrationComplete        = 4'd8,
        ConfigrationIdle            = 4'd9,
        L0                          = 4'd10,
        Idle                        = 4'd15
    } ltssmState_t;

    localparam logic [2:0] OsTs1   = 3'd0;
    localparam logic [2:0] OsTs2   = 3'd1;
    localparam logic [2:0] OsIdle  = 3'd4;
    localparam logic [3:0] PollThr = 4'(POLL_CNT);
    localparam logic [3:0] CfgThr  = 4'(CFG_CNT);
    localparam logic [3:0] IdleThr = 4'(IDLE_CNT);
    localparam logic [2:0] MaxGen  = 3'(MAX_GEN);
    localparam bit         IsUp    = (DEVICETYPE != 0);

    // State is kept as raw bits so undefined codes from the main LTSSM are
    // tracked (and simply never qualify) instead of being aliased.
    logic [3:0] State;
    logic [3:0] Cnt;
    logic       Done;
    logic       candValid;   // upstream Config.LinkWidthStart link candidate
    logic [7:0] candLink;

    logic       stateChange, isTs1, isTs2, isIdle, match;
    logic       qualify, reload, hasExit, exitNow, writeNow, rateNow;
    logic [3:0] threshold, target, cntInc, cntNext;
    logic [7:0] linkRef;
    logic [2:0] rateCapped;
    logic       unusedLaneNum;

    // The lane number value itself never decides anything; only its PAD flag does.
    assign unusedLaneNum = ^RxLaneNum;

    assign stateChange = (SetRXState != State);
    assign isTs1       = (OSType == OsTs1);
    assign isTs2       = (OSType == OsTs2);
    assign isIdle      = (OSType == OsIdle);
    assign linkRef     = IsUp ? WriteLinkNum : ReadLinkNum;
    assign match       = !RxLinkPad && (RxLinkNum == linkRef);
    assign cntInc      = (Cnt == 4'd15) ? Cnt : Cnt + 4'd1;
    assign rateCapped  = (RxRate > MaxGen) ? MaxGen : RxRate;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        qualify   = 1'b0;
        reload    = 1'b0;
        hasExit   = 1'b0;
        threshold = PollThr;
        target    = DetectQuiet;
        case (State)
            PollingActive: begin
                qualify = (isTs1 || isTs2) && RxLinkPad && RxLanePad;
                hasExit = 1'b1;
                target  = PollingConfigration;
            end
            PollingConfigration: begin
                qualify = isTs2 && RxLinkPad && RxLanePad;
                hasExit = 1'b1;
                target  = ConfigrationLinkWidthStart;
            end
            ConfigrationLinkWidthStart: begin
                if (IsUp) begin
                    // First non-PAD link number becomes the candidate; a different
                    // one restarts the run with itself as the new candidate.
                    qualify = isTs1 && !RxLinkPad && (!candValid || RxLinkNum == candLink);
                    reload  = isTs1 && !RxLinkPad && candValid && (RxLinkNum != candLink);
                end else begin
                    qualify = isTs1 && match;
                end
                hasExit   = 1'b1;
                threshold = CfgThr;
                target    = ConfigrationLinkWidthAccept;
            end
            ConfigrationLinkWidthAccept: begin
                qualify   = isTs1 && match && (!IsUp || !RxLanePad);
                hasExit   = 1'b1;
                threshold = CfgThr;
                target    = ConfigrationLaneNumWait;
            end
            ConfigrationLaneNumWait: begin
                qualify   = isTs1 && match && !RxLanePad;
                hasExit   = 1'b1;
                threshold = CfgThr;
                target    = ConfigrationLaneNumActive;
            end
            ConfigrationLaneNumActive: begin
                qualify   = (IsUp ? isTs2 : isTs1) && match && !RxLanePad;
                hasExit   = 1'b1;
                threshold = CfgThr;
                target    = ConfigrationComplete;
            end
            ConfigrationComplete: begin
                qualify = isTs2 && match && !RxLanePad;
                hasExit = 1'b1;
                target  = ConfigrationIdle;
            end
            ConfigrationIdle: begin
                qualify   = isIdle;
                hasExit   = 1'b1;
                threshold = IdleThr;
                target    = L0;
            end
            default: ;
        endcase

        // A state change wins over any OS arriving in the same cycle.
        if (stateChange)   cntNext = 4'd0;
        else if (!OSValid) cntNext = Cnt;
        else if (qualify)  cntNext = cntInc;
        else if (reload)   cntNext = 4'd1;
        else               cntNext = 4'd0;

        exitNow  = !stateChange && OSValid && (qualify || reload) && hasExit
                   && !Done && (cntNext >= threshold);
        writeNow = exitNow && IsUp && (State == ConfigrationLinkWidthStart);
        rateNow  = !stateChange && OSValid && qualify && (State == PollingConfigration);
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Pclk) begin
        if (!Reset) begin
            State            <= Idle;
            Cnt              <= 4'd0;
            Done             <= 1'b0;
            candValid        <= 1'b0;
            candLink         <= 8'd0;
            RXFinishFlag     <= 1'b0;
            RXExitTo         <= DetectQuiet;
            WriteLinkNum     <= 8'd0;
            WriteLinkNumFlag <= 1'b0;
            LinkRate         <= 3'd1;
        end else begin
            State            <= SetRXState;
            Cnt              <= cntNext;
            Done             <= stateChange ? 1'b0 : (Done || exitNow);
            RXFinishFlag     <= exitNow;
            WriteLinkNumFlag <= writeNow;
            if (exitNow)  RXExitTo     <= target;
            if (writeNow) WriteLinkNum <= RxLinkNum;
            if (rateNow)  LinkRate     <= rateCapped;
            if (stateChange) begin
                candValid <= 1'b0;
            end else if (OSValid && (qualify || reload) && IsUp
                         && (State == ConfigrationLinkWidthStart)) begin
                candValid <= 1'b1;
                candLink  <= RxLinkNum;
            end
        end
    end

endmodule

// File: tb/tb_rx_ltssm.sv
// ---------------------------------------------------------------------------
// tb_rx_ltssm -- self-checking bench for rx_ltssm.
//
// A downstream (MAX_GEN=1) and an upstream (MAX_GEN=2) instance see the same
// OS stream. Whenever the stimulus sends the OS that should complete an exit,
// the expected next state and cycle are pushed to a per-instance queue; a
// negedge monitor pops and compares on every RXFinishFlag pulse and flags any
// pulse that was not expected.
// ---------------------------------------------------------------------------
module tb_rx_ltssm;

    logic       Pclk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] SetRXState = 4'd15;
    logic       OSValid = 1'b0;
    logic [2:0] OSType = 3'd7;
    logic [7:0] RxLinkNum = 8'd0;
    logic       RxLinkPad = 1'b1;
    logic [7:0] RxLaneNum = 8'd0;
    logic       RxLanePad = 1'b1;
    logic [2:0] RxRate = 3'd1;
    logic [7:0] ReadLinkNum = 8'h05;

    logic       dnFlag, upFlag, dnWlnFlag, upWlnFlag;
    logic [3:0] dnExitTo, upExitTo;
    logic [7:0] dnWln, upWln;
    logic [2:0] dnRate, upRate;

    rx_ltssm #(.DEVICETYPE(0), .MAX_GEN(1)) dutDn (
        .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
        .RXFinishFlag(dnFlag), .RXExitTo(dnExitTo),
        .OSValid(OSValid), .OSType(OSType),
        .RxLinkNum(RxLinkNum), .RxLinkPad(RxLinkPad),
        .RxLaneNum(RxLaneNum), .RxLanePad(RxLanePad), .RxRate(RxRate),
        .ReadLinkNum(ReadLinkNum), .WriteLinkNum(dnWln),
        .WriteLinkNumFlag(dnWlnFlag), .LinkRate(dnRate)
    );

    rx_ltssm #(.DEVICETYPE(1), .MAX_GEN(2)) dutUp (
        .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
        .RXFinishFlag(upFlag), .RXExitTo(upExitTo),
        .OSValid(OSValid), .OSType(OSType),
        .RxLinkNum(RxLinkNum), .RxLinkPad(RxLinkPad),
        .RxLaneNum(RxLaneNum), .RxLanePad(RxLanePad), .RxRate(RxRate),
        .ReadLinkNum(ReadLinkNum), .WriteLinkNum(upWln),
        .WriteLinkNumFlag(upWlnFlag), .LinkRate(upRate)
    );

    always #5 Pclk = ~Pclk;

    int cyc = 0;
    always @(posedge Pclk) cyc <= cyc + 1;

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] exitTo;
        int         cyc;
    } exp_t;

    exp_t qDn[$];
    exp_t qUp[$];
    exp_t eDn, eUp;
    int   lastCyc = 0;

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    always @(negedge Pclk) begin
        if (dnFlag) begin
            if (qDn.size() == 0) check("dnUnexpectedFlag", 1, 0);
            else begin
                eDn = qDn.pop_front();
                check("dnExitTo", dnExitTo, eDn.exitTo);
                check("dnFlagCycle", cyc, eDn.cyc);
            end
        end
        if (upFlag) begin
            if (qUp.size() == 0) check("upUnexpectedFlag", 1, 0);
            else begin
                eUp = qUp.pop_front();
                check("upExitTo", upExitTo, eUp.exitTo);
                check("upFlagCycle", cyc, eUp.cyc);
            end
        end
        if (upWlnFlag) check("upWlnFlagWithFinish", upFlag, 1);
        if (dnWlnFlag) check("dnWlnFlagNever", dnWlnFlag, 0);
    end

    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    task automatic goState(input logic [3:0] s);
        SetRXState = s;
        tick();
    endtask

    task automatic sendOs(input logic [2:0] t, input logic lp, input logic [7:0] ln,
                          input logic np, input logic [7:0] nn, input logic [2:0] rate);
        OSValid   = 1'b1;
        OSType    = t;
        RxLinkPad = lp;
        RxLinkNum = ln;
        RxLanePad = np;
        RxLaneNum = nn;
        RxRate    = rate;
        tick();
        OSValid = 1'b0;
        lastCyc = cyc;
    endtask

    // Expect a pulse one cycle after the OS just sent.
    task automatic expectExit(input bit onDn, input bit onUp, input logic [3:0] to);
        exp_t e;
        e.exitTo = to;
        e.cyc    = lastCyc;
        if (onDn) qDn.push_back(e);
        if (onUp) qUp.push_back(e);
    endtask

    task automatic settle(input string tag);
        repeat (3) tick();
        check({tag, "_dnPending"}, qDn.size(), 0);
        check({tag, "_upPending"}, qUp.size(), 0);
    endtask

    localparam logic [2:0] TS1 = 3'd0, TS2 = 3'd1, IDL = 3'd4;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rstDnFlag", dnFlag, 0);
        check("rstDnExitTo", dnExitTo, 4'd0);
        check("rstDnRate", dnRate, 3'd1);
        check("rstUpWln", upWln, 8'd0);
        check("rstUpWlnFlag", upWlnFlag, 0);
        Reset = 1'b1;
        settle("idle");

        // PollingActive: 8 PAD TS1 -> one pulse to PollingConfigration; 9th silent
        goState(4'd2);
        for (int i = 0; i < 8; i++) sendOs(TS1, 1, 8'h00, 1, 8'h00, 3'd1);
        expectExit(1, 1, 4'd3);
        sendOs(TS1, 1, 8'h00, 1, 8'h00, 3'd1);
        settle("pollAct");
        check("exitToHolds", dnExitTo, 4'd3);

        // PollingActive revisit: non-PAD link breaks the run
        goState(4'd0);
        goState(4'd2);
        for (int i = 0; i < 5; i++) sendOs(TS1, 1, 8'h00, 1, 8'h00, 3'd1);
        sendOs(TS1, 0, 8'h01, 1, 8'h00, 3'd1);
        for (int i = 0; i < 8; i++) sendOs(TS1, 1, 8'h00, 1, 8'h00, 3'd1);
        expectExit(1, 1, 4'd3);
        settle("pollBreak");

        // PollingConfigration: rate capped at each instance's MAX_GEN
        goState(4'd3);
        for (int i = 0; i < 8; i++) sendOs(TS2, 1, 8'h00, 1, 8'h00, 3'd3);
        expectExit(1, 1, 4'd4);
        settle("pollCfg");
        check("dnLinkRate", dnRate, 3'd1);
        check("upLinkRate", upRate, 3'd2);

        // LinkWidthStart: 0x07 then 0x05,0x05 -> upstream candidate restarts
        goState(4'd4);
        sendOs(TS1, 0, 8'h07, 1, 8'h00, 3'd1);
        sendOs(TS1, 0, 8'h05, 1, 8'h00, 3'd1);
        sendOs(TS1, 0, 8'h05, 1, 8'h00, 3'd1);
        expectExit(1, 1, 4'd5);
        @(negedge Pclk);
        check("upWlnFlagPulse", upWlnFlag, 1);
        check("upWlnValue", upWln, 8'h05);
        tick();
        check("upWlnFlagDrop", upWlnFlag, 0);
        settle("lws");

        // LinkWidthAccept: lane PAD qualifies only downstream
        goState(4'd5);
        sendOs(TS1, 0, 8'h05, 1, 8'h00, 3'd1);
        sendOs(TS1, 0, 8'h05, 0, 8'h00, 3'd1);
        expectExit(1, 0, 4'd6);
        sendOs(TS1, 0, 8'h05, 0, 8'h00, 3'd1);
        expectExit(0, 1, 4'd6);
        settle("lwa");

        // LaneNumWait
        goState(4'd6);
        sendOs(TS1, 0, 8'h05, 0, 8'h01, 3'd1);
        sendOs(TS1, 0, 8'h05, 0, 8'h01, 3'd1);
        expectExit(1, 1, 4'd7);
        settle("lnw");

        // LaneNumActive: downstream wants TS1, upstream TS2
        goState(4'd7);
        sendOs(TS1, 0, 8'h05, 0, 8'h00, 3'd1);
        sendOs(TS1, 0, 8'h05, 0, 8'h00, 3'd1);
        expectExit(1, 0, 4'd8);
        sendOs(TS2, 0, 8'h05, 0, 8'h00, 3'd1);
        sendOs(TS2, 0, 8'h05, 0, 8'h00, 3'd1);
        expectExit(0, 1, 4'd8);
        settle("lna");

        // ConfigrationComplete
        goState(4'd8);
        for (int i = 0; i < 8; i++) sendOs(TS2, 0, 8'h05, 0, 8'h00, 3'd1);
        expectExit(1, 1, 4'd9);
        settle("cfgCpl");

        // ConfigrationIdle: 7 IDLE, leave, 8 IDLE in L0, return (with an OS
        // on the change edge that must be ignored), then 8 IDLE
        goState(4'd9);
        for (int i = 0; i < 7; i++) sendOs(IDL, 1, 8'h00, 1, 8'h00, 3'd1);
        goState(4'd10);
        for (int i = 0; i < 8; i++) sendOs(IDL, 1, 8'h00, 1, 8'h00, 3'd1);
        settle("l0NoFlag");
        SetRXState = 4'd9;
        sendOs(IDL, 1, 8'h00, 1, 8'h00, 3'd1);
        for (int i = 0; i < 8; i++) sendOs(IDL, 1, 8'h00, 1, 8'h00, 3'd1);
        expectExit(1, 1, 4'd10);
        settle("cfgIdle");

        // Reset lands on the threshold OS: no pulse, registers back to reset
        goState(4'd2);
        for (int i = 0; i < 7; i++) sendOs(TS1, 1, 8'h00, 1, 8'h00, 3'd1);
        Reset = 1'b0;
        sendOs(TS1, 1, 8'h00, 1, 8'h00, 3'd1);
        tick();
        check("midRstDnFlag", dnFlag, 0);
        check("midRstDnExitTo", dnExitTo, 4'd0);
        check("midRstUpExitTo", upExitTo, 4'd0);
        check("midRstUpRate", upRate, 3'd1);
        check("midRstUpWln", upWln, 8'd0);
        Reset = 1'b1;
        settle("midRst");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
